// File: rtl/dcpu16_arb.sv
// dcpu16_arb: merges the core's fetch/save bus (FBUS, f_*) and operand bus
// (ABUS, g_*) onto one single-port memory bus (x_*). Round-robin grant,
// registered one-cycle acks, and a watchdog that aborts a hung memory cycle
// so the core pipeline can never deadlock.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no transfer outstanding, arbitrating between f and g
// GF    | FBUS granted, x_stb high, waiting for x_ack or watchdog
// GG    | ABUS granted, x_stb high, waiting for x_ack or watchdog
module dcpu16_arb #(
  parameter int AW  = 16,
  parameter int DW  = 16,
  parameter int TMO = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] f_adr,
  input  logic          f_stb,
  input  logic          f_wre,
  input  logic [DW-1:0] f_dto,
  output logic [DW-1:0] f_dti,
  output logic          f_ack,
  input  logic [AW-1:0] g_adr,
  input  logic          g_stb,
  input  logic          g_wre,
  input  logic [DW-1:0] g_dto,
  output logic [DW-1:0] g_dti,
  output logic          g_ack,
  output logic [AW-1:0] x_adr,
  output logic          x_stb,
  output logic          x_wre,
  output logic [DW-1:0] x_dto,
  input  logic [DW-1:0] x_dti,
  input  logic          x_ack,
  output logic          err
);

  // Watchdog counter wide enough to hold TMO; one bit when disabled.
  localparam int WW = (TMO > 0) ? $clog2(TMO + 1) : 1;
  localparam logic [WW-1:0] WD_LAST = WW'(TMO - 1);
  localparam logic [WW-1:0] WD_MAX  = WW'(TMO);

  typedef enum logic [1:0] {IDLE, GF, GG} state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;   // 1: ABUS was granted last
  logic [WW-1:0] wdog_q, wdog_d;
  logic [AW-1:0] x_adr_q, x_adr_d;
  logic          x_stb_q, x_stb_d;
  logic          x_wre_q, x_wre_d;
  logic [DW-1:0] x_dto_q, x_dto_d;
  logic [DW-1:0] f_dti_q, f_dti_d;
  logic [DW-1:0] g_dti_q, g_dti_d;
  logic          f_ack_q, f_ack_d;
  logic          g_ack_q, g_ack_d;
  logic          err_q, err_d;

  logic f_elig, g_elig, pick_g, abort;

  // Next-state, grant decision and completion/abort handling.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    wdog_d  = wdog_q;
    x_adr_d = x_adr_q;
    x_stb_d = x_stb_q;
    x_wre_d = x_wre_q;
    x_dto_d = x_dto_q;
    f_dti_d = f_dti_q;
    g_dti_d = g_dti_q;
    f_ack_d = 1'b0;
    g_ack_d = 1'b0;
    err_d   = 1'b0;
    // A strobe still high in the cycle its ack is visible is the old request.
    f_elig  = f_stb & ~f_ack_q;
    g_elig  = g_stb & ~g_ack_q;
    pick_g  = g_elig & (~f_elig | ~last_q);
    abort   = (TMO != 0) && (wdog_q == WD_LAST);

    case (state_q)
      IDLE: begin
        if (f_elig | g_elig) begin
          x_stb_d = 1'b1;
          wdog_d  = '0;
          if (pick_g) begin
            state_d = GG;
            last_d  = 1'b1;
            x_adr_d = g_adr;
            x_wre_d = g_wre;
            x_dto_d = g_dto;
          end else begin
            state_d = GF;
            last_d  = 1'b0;
            x_adr_d = f_adr;
            x_wre_d = f_wre;
            x_dto_d = f_dto;
          end
        end
      end
      GF, GG: begin
        if (x_ack) begin
          x_stb_d = 1'b0;
          state_d = IDLE;
          if (state_q == GF) begin
            f_dti_d = x_dti;
            f_ack_d = 1'b1;
          end else begin
            g_dti_d = x_dti;
            g_ack_d = 1'b1;
          end
        end else if (abort) begin
          x_stb_d = 1'b0;
          state_d = IDLE;
          err_d   = 1'b1;
          if (state_q == GF) begin
            f_dti_d = '1;
            f_ack_d = 1'b1;
          end else begin
            g_dti_d = '1;
            g_ack_d = 1'b1;
          end
        end else if (wdog_q != WD_MAX) begin
          wdog_d = wdog_q + WW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      wdog_q  <= '0;
      x_adr_q <= '0;
      x_stb_q <= 1'b0;
      x_wre_q <= 1'b0;
      x_dto_q <= '0;
      f_dti_q <= '0;
      g_dti_q <= '0;
      f_ack_q <= 1'b0;
      g_ack_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
      x_adr_q <= x_adr_d;
      x_stb_q <= x_stb_d;
      x_wre_q <= x_wre_d;
      x_dto_q <= x_dto_d;
      f_dti_q <= f_dti_d;
      g_dti_q <= g_dti_d;
      f_ack_q <= f_ack_d;
      g_ack_q <= g_ack_d;
      err_q   <= err_d;
    end
  end

  assign x_adr = x_adr_q;
  assign x_stb = x_stb_q;
  assign x_wre = x_wre_q;
  assign x_dto = x_dto_q;
  assign f_dti = f_dti_q;
  assign g_dti = g_dti_q;
  assign f_ack = f_ack_q;
  assign g_ack = g_ack_q;
  assign err   = err_q;

endmodule

// File: tb/tb_dcpu16_arb.sv
// Bench for dcpu16_arb: directed scenarios followed by a randomized phase
// checked against a transaction-level memory and fairness model.
module tb_dcpu16_arb;
  localparam int AW = 16, DW = 16, TMO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] f_adr, g_adr, x_adr;
  logic          f_stb, f_wre, g_stb, g_wre;
  logic [DW-1:0] f_dto, g_dto, f_dti, g_dti, x_dto;
  logic          f_ack, g_ack, x_stb, x_wre, err;
  logic [DW-1:0] x_dti;
  logic          x_ack;

  dcpu16_arb #(.AW(AW), .DW(DW), .TMO(TMO)) dut (
    .clk(clk), .rst(rst),
    .f_adr(f_adr), .f_stb(f_stb), .f_wre(f_wre), .f_dto(f_dto), .f_dti(f_dti), .f_ack(f_ack),
    .g_adr(g_adr), .g_stb(g_stb), .g_wre(g_wre), .g_dto(g_dto), .g_dti(g_dti), .g_ack(g_ack),
    .x_adr(x_adr), .x_stb(x_stb), .x_wre(x_wre), .x_dto(x_dto), .x_dti(x_dti), .x_ack(x_ack),
    .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int mem_lat = 0;
  bit mem_hang = 1'b0, stray_ack = 1'b0;
  logic [15:0] acc_adr, acc_dto;
  logic        acc_wre;
  logic [15:0] ref_mem [256];

  function automatic logic [15:0] init_val(input int i);
    return (i == 16) ? 16'h7C01 : 16'(i * 40503 + 77);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step until master m (0=f, 1=g) acks or the bound runs out.
  task automatic wait_ack(input int m, input int bound, output int n, output bit got,
                          output bit err_seen, output bit other_ack);
    n = 0; got = 1'b0; err_seen = 1'b0; other_ack = 1'b0;
    while (!got && n < bound) begin
      step();
      n++;
      if (err) err_seen = 1'b1;
      if ((m == 0) ? g_ack : f_ack) other_ack = 1'b1;
      got = (m == 0) ? f_ack : g_ack;
    end
  endtask

  // Memory model: latency mem_lat wait cycles, optional hang, stray acks.
  initial begin : mem_model
    logic [15:0] mem [256];
    int wcnt;
    for (int i = 0; i < 256; i++) mem[i] = init_val(i);
    wcnt = 0; x_ack = 1'b0; x_dti = '0;
    acc_adr = '0; acc_dto = '0; acc_wre = 1'b0;
    forever begin
      @(negedge clk);
      x_ack = 1'b0;
      if (stray_ack) begin
        x_ack = 1'b1;
        x_dti = 16'($urandom);
      end else if (x_stb === 1'b1 && !mem_hang) begin
        if (wcnt >= mem_lat) begin
          x_ack   = 1'b1;
          x_dti   = mem[x_adr[7:0]];
          acc_adr = x_adr; acc_wre = x_wre; acc_dto = x_dto;
          if (x_wre) mem[x_adr[7:0]] = x_dto;
          wcnt = 0;
        end else wcnt++;
      end else wcnt = 0;
    end
  end

  initial begin
    int n, t0, mn, ew, pm, pa;
    bit got, es, oa, any;
    logic [15:0] expv;
    int order [4];
    bit busy [2], linger [2], prev_ack [2], acks [2], rwre [2], stb_v [2];
    logic [15:0] radr [2], rdto [2], dtis [2];
    int start_cyc [2];

    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    rst = 1'b1;
    f_adr = '0; f_stb = 0; f_wre = 0; f_dto = '0;
    g_adr = '0; g_stb = 0; g_wre = 0; g_dto = '0;
    step(); step();
    chk("rst_xstb", x_stb, 0); chk("rst_xwre", x_wre, 0); chk("rst_xadr", x_adr, 0);
    chk("rst_xdto", x_dto, 0); chk("rst_fack", f_ack, 0); chk("rst_gack", g_ack, 0);
    chk("rst_fdti", f_dti, 0); chk("rst_gdti", g_dti, 0); chk("rst_err", err, 0);
    rst = 1'b0;

    // single read, one wait cycle
    mem_lat = 1;
    f_adr = 16'h0010; f_wre = 0; f_dto = 16'hDEAD; f_stb = 1;
    step();
    chk("rd_xstb", x_stb, 1); chk("rd_xadr", x_adr, 16'h0010); chk("rd_xwre", x_wre, 0);
    wait_ack(0, 10, n, got, es, oa);
    chk("rd_lat", n + 1, 3); chk("rd_dti", f_dti, 16'h7C01); chk("rd_gack", oa, 0);
    f_stb = 0;
    step();
    chk("rd_pulse", f_ack, 0);

    // write on ABUS
    mem_lat = 0;
    expv = ref_mem[8'h00];
    g_adr = 16'h8000; g_wre = 1; g_dto = 16'h1234; g_stb = 1;
    step();
    chk("wr_xwre", x_wre, 1); chk("wr_xdto", x_dto, 16'h1234); chk("wr_xadr", x_adr, 16'h8000);
    wait_ack(1, 10, n, got, es, oa);
    chk("wr_ack", got, 1); chk("wr_dti", g_dti, expv); chk("wr_fdti", f_dti, 16'h7C01);
    ref_mem[8'h00] = 16'h1234;
    g_stb = 0; g_wre = 0;
    step();
    chk("wr_pulse", g_ack, 0);

    // ack masking: stb held one cycle past its ack
    f_adr = 16'h0020; f_stb = 1;
    wait_ack(0, 10, n, got, es, oa);
    chk("msk_ack", got, 1); chk("msk_dti", f_dti, ref_mem[8'h20]);
    step();
    chk("msk_xstb", x_stb, 0); chk("msk_fack", f_ack, 0);
    f_stb = 0;
    step();

    // watchdog abort on a hung memory
    mem_hang = 1;
    f_adr = 16'h0030; f_stb = 1;
    step();
    n = 0;
    while (x_stb && n < 20) begin n++; step(); end
    chk("wd_len", n, TMO); chk("wd_fack", f_ack, 1); chk("wd_fdti", f_dti, 16'hFFFF);
    chk("wd_err", err, 1);
    f_stb = 0; mem_hang = 0;
    step();
    chk("wd_err_pulse", err, 0); chk("wd_ack_pulse", f_ack, 0);
    mem_lat = 1;
    g_adr = 16'h0040; g_stb = 1;
    wait_ack(1, 10, n, got, es, oa);
    chk("wd_next_ack", got, 1); chk("wd_next_dti", g_dti, ref_mem[8'h40]); chk("wd_next_err", es, 0);
    g_stb = 0;
    step();

    // x_ack coinciding with the abort cycle wins
    mem_lat = 3;
    f_adr = 16'h0050; f_stb = 1;
    wait_ack(0, 12, n, got, es, oa);
    chk("col_lat", n, 5); chk("col_dti", f_dti, ref_mem[8'h50]); chk("col_err", es | err, 0);
    f_stb = 0;
    step();

    // x_ack while idle is ignored
    stray_ack = 1; any = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (x_stb | f_ack | g_ack | err) any = 1;
    end
    stray_ack = 0;
    chk("stray", any, 0);

    // input changes and stb drop during a granted transfer
    mem_lat = 2;
    expv = ref_mem[8'h60];
    g_adr = 16'h0060; g_wre = 1; g_dto = 16'hA5A5; g_stb = 1;
    step();
    g_adr = 16'h0061; g_wre = 0; g_dto = 16'h5A5A; g_stb = 0;
    step();
    chk("hold_xadr", x_adr, 16'h0060); chk("hold_xdto", x_dto, 16'hA5A5); chk("hold_xwre", x_wre, 1);
    wait_ack(1, 10, n, got, es, oa);
    chk("hold_ack", got, 1); chk("hold_acc_adr", acc_adr, 16'h0060); chk("hold_acc_dto", acc_dto, 16'hA5A5);
    chk("hold_dti", g_dti, expv);
    ref_mem[8'h60] = 16'hA5A5;
    g_wre = 0;
    step();

    // reset mid-transfer, then contention from reset
    mem_hang = 1;
    g_adr = 16'h0070; g_stb = 1;
    step();
    chk("rmt_xstb_on", x_stb, 1);
    rst = 1; g_stb = 0;
    step();
    chk("rmt_xstb", x_stb, 0); chk("rmt_gack", g_ack, 0); chk("rmt_err", err, 0);
    rst = 0; mem_hang = 0; mem_lat = 0;
    f_adr = 16'h0071; g_adr = 16'h0072; f_stb = 1; g_stb = 1;
    for (int i = 0; i < 4; i++) order[i] = 2;
    n = 0; mn = 0;
    while (mn < 4 && n < 40) begin
      step(); n++;
      if (f_ack) begin order[mn] = 0; chk("cont_fdti", f_dti, ref_mem[8'h71]); mn++; end
      else if (g_ack) begin order[mn] = 1; chk("cont_gdti", g_dti, ref_mem[8'h72]); mn++; end
    end
    f_stb = 0; g_stb = 0;
    chk("cont_0", order[0], 0); chk("cont_1", order[1], 1);
    chk("cont_2", order[2], 0); chk("cont_3", order[3], 1);
    step(); step();

    // randomized phase
    pm = 1; pa = 0;
    for (int m = 0; m < 2; m++) begin
      busy[m] = 0; linger[m] = 0; prev_ack[m] = 0; stb_v[m] = 0; rwre[m] = 0;
      radr[m] = '0; rdto[m] = '0; start_cyc[m] = 0;
    end
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      mem_lat = $urandom_range(0, 2);
      step();
      chk("rnd_err", err, 0);
      acks[0] = f_ack; acks[1] = g_ack; dtis[0] = f_dti; dtis[1] = g_dti;
      for (int m = 0; m < 2; m++) begin
        int o;
        o = 1 - m;
        if (acks[m]) begin
          chk("rnd_dbl", prev_ack[m], 0);
          chk("rnd_req", busy[m], 1);
          chk("rnd_dti", dtis[m], ref_mem[radr[m][7:0]]);
          chk("rnd_adr", acc_adr, radr[m]);
          chk("rnd_wre", acc_wre, rwre[m]);
          if (rwre[m]) begin
            chk("rnd_dto", acc_dto, rdto[m]);
            ref_mem[radr[m][7:0]] = rdto[m];
          end
          t0 = pa; mn = start_cyc[m];
          if (busy[o] && start_cyc[o] < mn) mn = start_cyc[o];
          if (mn > t0) t0 = mn;
          if (busy[o] && start_cyc[o] <= t0) begin
            ew = (start_cyc[m] <= t0) ? 1 - pm : o;
            chk("rnd_rr", m, ew);
          end
          pm = m; pa = cyc;
          busy[m] = 0;
          linger[m] = 1'($urandom_range(0, 1));
          stb_v[m] = linger[m];
        end else if (linger[m]) begin
          linger[m] = 0; stb_v[m] = 0;
        end else if (!busy[m]) begin
          if ($urandom_range(0, 2) == 0) begin
            radr[m] = {8'($urandom), 4'h0, 4'($urandom_range(0, 15))};
            rwre[m] = 1'($urandom_range(0, 1));
            rdto[m] = 16'($urandom);
            busy[m] = 1; start_cyc[m] = cyc; stb_v[m] = 1;
          end
        end else if (cyc - start_cyc[m] > 100) begin
          errors++;
          $error("FAIL rnd_timeout master %0d waited %0d cycles, limit 100", m, cyc - start_cyc[m]);
          busy[m] = 0; stb_v[m] = 0;
        end
        prev_ack[m] = acks[m];
      end
      f_stb = stb_v[0]; f_adr = radr[0]; f_wre = rwre[0]; f_dto = rdto[0];
      g_stb = stb_v[1]; g_adr = radr[1]; g_wre = rwre[1]; g_dto = rdto[1];
    end
    f_stb = 0; g_stb = 0;
    for (int i = 0; i < 8; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dcpu16_arb.md
Name: dcpu16_arb

Overview:
- Memory-side arbiter directly downstream of the dcpu16 core.
- Merges the core's two master buses onto one external single-port memory bus (x_*):
  - FBUS (f_*): instruction fetch and result save.
  - ABUS (g_*): operand load/store.
- Round-robin grant, registered single-cycle acks, and a watchdog that terminates hung transfers so the core's pipeline never deadlocks.

Parameters:
- AW, 16, address width of all buses.
- DW, 16, data width of all buses.
- TMO, 255, max wait cycles for x_ack before abort; 0 disables the watchdog.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- f_adr  in  AW  FBUS address from core.
- f_stb  in  1  FBUS request; held high until f_ack.
- f_wre  in  1  FBUS write enable.
- f_dto  in  DW  FBUS write data from core.
- f_dti  out  DW  FBUS read data to core.
- f_ack  out  1  FBUS transfer complete, one-cycle pulse.
- g_adr  in  AW  ABUS address.
- g_stb  in  1  ABUS request.
- g_wre  in  1  ABUS write enable.
- g_dto  in  DW  ABUS write data.
- g_dti  out  DW  ABUS read data.
- g_ack  out  1  ABUS transfer complete, one-cycle pulse.
- x_adr  out  AW  memory address.
- x_stb  out  1  memory request.
- x_wre  out  1  memory write enable.
- x_dto  out  DW  memory write data.
- x_dti  in  DW  memory read data.
- x_ack  in  1  memory transfer complete.
- err  out  1  watchdog abort, one-cycle pulse.

Behaviour:
- Single clock domain. Reset is synchronous and active-high, sampled on rising clk.
- Reset values:
  - state=IDLE, last=G.
  - x_stb=0, x_wre=0, x_adr=0, x_dto=0.
  - f_ack=0, g_ack=0, f_dti=0, g_dti=0, err=0, wdog=0.
- FSM states: IDLE, GF (FBUS granted), GG (ABUS granted).
- IDLE eligibility:
  - f is eligible if f_stb=1 and f_ack=0.
  - g is eligible if g_stb=1 and g_ack=0.
  - This masks the stb still high in the cycle after its ack.
- IDLE grant:
  - Only f eligible -> GF. Only g eligible -> GG.
  - Both eligible -> grant the master not equal to last (round-robin). After reset FBUS wins first.
  - On grant, register x_adr/x_wre/x_dto from the granted master, set x_stb=1, update last, clear wdog.
  - First memory strobe appears 1 cycle after a request is seen in IDLE.
- GF/GG with x_ack=1:
  - Capture x_dti into the granted master's dti (also on writes).
  - Pulse that master's ack for exactly 1 cycle.
  - x_stb=0, state -> IDLE.
  - The other master's dti is unchanged.
- GF/GG with x_ack=0:
  - x_* outputs held stable; wdog increments by 1, saturating at TMO.
- Watchdog, TMO!=0:
  - If wdog==TMO-1 and x_ack=0, abort: x_stb=0, granted master receives ack with dti={DW{1}}, err=1 for one cycle, state -> IDLE.
  - x_ack in the same cycle as the abort condition: x_ack wins, normal completion, no err.
- Master inputs are sampled only at grant. Changes to adr/wre/dto during a granted transfer are ignored.
- A master dropping stb before ack (protocol violation) does not cancel the granted transfer.
- Minimum turnaround: 1 IDLE cycle between transfers. Back-to-back alternating requests give 3 cycles per transfer with a 1-cycle-ack memory.
- x_ack while in IDLE is ignored.
- rst mid-transfer: all state and outputs return to reset values on the next edge. No ack is issued for the aborted transfer.
- Latency: request-seen to ack = 2 + memory wait cycles.

Test Plan:
- Single read: f_stb=1, f_adr=0x0010, memory returns 0x7C01 with x_ack one cycle after x_stb -> x_adr=0x0010, x_wre=0; f_dti=0x7C01, f_ack pulses 1 cycle; g_ack stays 0.
- Write: g_stb=1, g_wre=1, g_adr=0x8000, g_dto=0x1234 -> x_wre=1, x_dto=0x1234, x_adr=0x8000; g_ack single pulse; f_dti unchanged.
- Contention: f_stb and g_stb both high from reset, each holding stb until its own ack -> grant order F, G, F, G. No master is acked twice for one strobe.
- Ack masking: master holds f_stb=1 one cycle after f_ack -> no second memory transfer is started for that cycle.
- Watchdog: TMO=4, f_stb=1, x_ack never asserted -> x_stb drops after 4 cycles; f_ack=1, f_dti=0xFFFF, err=1 for exactly one cycle. A following g request then completes normally.
- Reset mid-transfer: rst=1 while in GG with x_stb=1 -> next cycle x_stb=0, g_ack=0, last=G. Next simultaneous request grants FBUS.
